// File: rtl/axil_imem_bridge.sv
// axil_imem_bridge: AXI4-Lite slave giving single-outstanding, full-word access to an instruction memory.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*            AXI4-Lite write address, data and response channels
//   s_axi_ar*/r*               AXI4-Lite read address and data channels
//   mem_we, mem_addr,          memory write enable, word address (held for the whole access),
//   mem_wdata, mem_rdata       write data, registered readback (valid two edges after mem_addr)
module axil_imem_bridge #(
    parameter int ADDR_W = 16,
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_WAIT, RD_CAP, RD_RESP} state_t;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    state_t            r_state, w_state;
    logic              r_awready, w_awready, r_arready, w_arready;
    logic              r_bvalid, w_bvalid, r_rvalid, w_rvalid;
    logic [1:0]        r_bresp, w_bresp, r_rresp, w_rresp;
    logic [31:0]       r_rdata, w_rdata, r_mem_wdata, w_mem_wdata;
    logic              r_mem_we, w_mem_we, r_last_wr, w_last_wr;
    logic [MEM_AW-1:0] r_mem_addr, w_mem_addr;
    logic              w_aw_hs, w_ar_hs, w_wr_req, w_rd_req, w_grant_wr, w_grant_rd;
    logic              w_aw_in, w_ar_in, w_wr_ok;
    logic              w_unused_lsbs;
    assign w_unused_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
    assign w_aw_in    = s_axi_awaddr[ADDR_W-1:MEM_AW+2] == '0;
    assign w_ar_in    = s_axi_araddr[ADDR_W-1:MEM_AW+2] == '0;
    assign w_wr_ok    = w_aw_in && s_axi_wstrb == 4'hF;
    assign w_aw_hs    = r_awready && s_axi_awvalid && s_axi_wvalid;
    assign w_ar_hs    = r_arready && s_axi_arvalid;
    assign w_wr_req   = s_axi_awvalid && s_axi_wvalid;
    assign w_rd_req   = s_axi_arvalid;
    // On contention the channel that lost the previous grant wins.
    assign w_grant_wr = w_wr_req && (!w_rd_req || !r_last_wr);
    assign w_grant_rd = w_rd_req && !w_grant_wr;
    always_comb begin
        w_state     = r_state;
        w_awready   = 1'b0;
        w_arready   = 1'b0;
        w_bvalid    = r_bvalid;
        w_bresp     = r_bresp;
        w_rvalid    = r_rvalid;
        w_rresp     = r_rresp;
        w_rdata     = r_rdata;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_last_wr   = r_last_wr;
        case (r_state)
            IDLE: begin
                if (w_aw_hs) begin
                    w_state     = w_wr_ok ? WR_ADDR : WR_RESP;
                    w_mem_addr  = s_axi_awaddr[MEM_AW+1:2];
                    w_mem_wdata = s_axi_wdata;
                    w_bresp     = w_wr_ok ? OKAY : SLVERR;
                end else if (w_ar_hs) begin
                    w_state    = w_ar_in ? RD_ADDR : RD_RESP;
                    w_mem_addr = s_axi_araddr[MEM_AW+1:2];
                    w_rresp    = w_ar_in ? OKAY : SLVERR;
                    w_rdata    = '0;
                end else if (!r_awready && !r_arready) begin
                    // Ready is a registered one-cycle offer; a withdrawn valid simply re-arbitrates.
                    w_awready = w_grant_wr;
                    w_arready = w_grant_rd;
                    w_last_wr = (w_grant_wr || w_grant_rd) ? w_grant_wr : r_last_wr;
                end
            end
            WR_ADDR: begin
                w_state  = WR_DATA;
                w_mem_we = 1'b1;
            end
            WR_DATA: begin
                w_state  = WR_RESP;
                w_bvalid = 1'b1;
            end
            // Error paths enter the response state with valid low and raise it one edge later.
            WR_RESP: begin
                w_bvalid = !r_bvalid || !s_axi_bready;
                w_state  = (r_bvalid && s_axi_bready) ? IDLE : WR_RESP;
            end
            RD_ADDR: w_state = RD_WAIT;
            RD_WAIT: w_state = RD_CAP;
            RD_CAP: begin
                w_state  = RD_RESP;
                w_rdata  = mem_rdata;
                w_rvalid = 1'b1;
            end
            RD_RESP: begin
                w_rvalid = !r_rvalid || !s_axi_rready;
                w_state  = (r_rvalid && s_axi_rready) ? IDLE : RD_RESP;
            end
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_awready   <= 1'b0;
            r_arready   <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= '0;
            r_rvalid    <= 1'b0;
            r_rresp     <= '0;
            r_rdata     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_last_wr   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_awready   <= w_awready;
            r_arready   <= w_arready;
            r_bvalid    <= w_bvalid;
            r_bresp     <= w_bresp;
            r_rvalid    <= w_rvalid;
            r_rresp     <= w_rresp;
            r_rdata     <= w_rdata;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_last_wr   <= w_last_wr;
        end
    end
    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_awready;
    assign s_axi_arready = r_arready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
endmodule

// File: tb/tb_axil_imem_bridge.sv
// tb_axil_imem_bridge: directed and randomized transactions checked against a transaction-level memory model.
`timescale 1ns/1ps
module tb_axil_imem_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid, mem_we;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [11:0] mem_addr;
    always #5 clk = ~clk;
    axil_imem_bridge #(.ADDR_W(16), .MEM_AW(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );
    function automatic logic [31:0] init_word(input int i);
        return (i == 5) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B1) ^ 32'h12345678;
    endfunction
    // Backing memory: address latched one edge, data registered on the next.
    logic [31:0] mem [4096];
    logic [31:0] exp_mem [4096];
    logic [11:0] lat_addr;
    logic        fill;
    always @(posedge clk) begin
        if (fill) for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        lat_addr  <= mem_addr;
        mem_rdata <= mem[lat_addr];
    end
    int          we_total = 0, bv_total = 0;
    logic [11:0] we_addr;
    logic [31:0] we_data;
    always @(negedge clk) begin
        if (mem_we) begin
            we_total <= we_total + 1;
            we_addr  <= mem_addr;
            we_data  <= mem_wdata;
        end
        if (bvalid) bv_total <= bv_total + 1;
    end
    int n_chk = 0, n_pass = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask
    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb, input bit pre, input int hold);
        bit legal;
        int n, lat, we0;
        legal = addr[15:14] == 2'b00 && strb == 4'hF;
        we0 = we_total;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1; bready = pre;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 20);
        check("w_accept", n, 1);
        check("w_wready", 32'(wready), 1);
        lat = -1;
        do begin @(negedge clk); awvalid = 0; wvalid = 0; lat++; end while (!bvalid && lat < 20);
        check("w_lat", lat, legal ? 2 : 1);
        check("w_bresp", 32'(bresp), legal ? 0 : 2);
        for (int i = 0; i < hold && !pre; i++) begin
            @(negedge clk);
            check("w_hold", 32'({bvalid, bresp}), legal ? 32'h4 : 32'h6);
        end
        bready = 1;
        @(negedge clk);
        check("w_done", 32'({bvalid, awready, arready}), 0);
        bready = 0;
        check("w_we_cnt", we_total - we0, legal ? 1 : 0);
        if (legal) begin
            check("w_we_addr", 32'(we_addr), 32'(addr[13:2]));
            check("w_we_data", we_data, data);
            exp_mem[addr[13:2]] = data;
        end
    endtask
    task automatic do_read(input logic [15:0] addr, input bit pre, input int hold);
        bit legal;
        int n, lat, we0;
        logic [31:0] exp_d;
        legal = addr[15:14] == 2'b00;
        exp_d = legal ? exp_mem[addr[13:2]] : 32'h0;
        we0 = we_total;
        araddr = addr; arvalid = 1; rready = pre;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 20);
        check("r_accept", n, 1);
        lat = -1;
        do begin @(negedge clk); arvalid = 0; lat++; end while (!rvalid && lat < 20);
        check("r_lat", lat, legal ? 3 : 1);
        check("r_data", rdata, exp_d);
        check("r_rresp", 32'(rresp), legal ? 0 : 2);
        for (int i = 0; i < hold && !pre; i++) begin
            @(negedge clk);
            check("r_hold", 32'({rvalid, rresp}), legal ? 32'h4 : 32'h6);
            check("r_hold_d", rdata, exp_d);
        end
        rready = 1;
        @(negedge clk);
        check("r_done", 32'({rvalid, awready, arready}), 0);
        rready = 0;
        check("r_no_we", we_total - we0, 0);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end
    initial begin
        int order [6];
        int cnt, n, we0, bv0;
        logic [15:0] a;
        rst_n = 0; fill = 1;
        awaddr = 0; araddr = 0; awvalid = 0; wvalid = 0; arvalid = 0;
        wdata = 0; wstrb = 0; bready = 0; rready = 0;
        for (int i = 0; i < 4096; i++) exp_mem[i] = init_word(i);
        repeat (2) @(negedge clk);
        fill = 0;
        check("rst_ctrl", 32'({awready, wready, arready, bvalid, rvalid, mem_we, bresp, rresp}), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        // Contending writes and reads straight out of reset alternate, write first.
        foreach (order[i]) order[i] = -1;
        awaddr = 16'h0040; wdata = 32'hA5A50001; wstrb = 4'hF; araddr = 16'h0040;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
        rst_n = 1;
        cnt = 0; n = 0;
        while (cnt < 6 && n < 200) begin
            @(negedge clk); n++;
            if (awready && awvalid) begin order[cnt] = 1; cnt++; end
            else if (arready && arvalid) begin order[cnt] = 0; cnt++; end
        end
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        repeat (8) @(negedge clk);
        bready = 0; rready = 0;
        exp_mem[16] = 32'hA5A50001;
        for (int i = 0; i < 6; i++) check("arb_order", order[i], (i % 2 == 0) ? 1 : 0);
        do_write(16'h0008, 32'h00000013, 4'hF, 1, 0);
        do_read(16'h0014, 1, 0);
        do_write(16'h000C, 32'h11112222, 4'h3, 0, 2);
        do_write(16'h4000, 32'h33334444, 4'hF, 1, 0);
        do_read(16'h4000, 0, 2);
        do_read(16'h000C, 1, 0);
        do_read(16'h0040, 0, 1);
        // Write response held off while a read waits behind it.
        awaddr = 16'h0020; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 20);
        @(negedge clk);
        awvalid = 0; wvalid = 0; araddr = 16'h0020; arvalid = 1;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        check("b2b_bvalid", 32'(bvalid), 1);
        repeat (5) begin
            @(negedge clk);
            check("b2b_hold", 32'({bvalid, bresp, awready, arready}), 32'h10);
        end
        bready = 1;
        @(negedge clk);
        check("b2b_done", 32'({bvalid, arready}), 0);
        bready = 0;
        @(negedge clk);
        check("b2b_accept", 32'(arready), 1);
        exp_mem[8] = 32'h0BADF00D;
        @(negedge clk);
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        check("b2b_rdata", rdata, 32'h0BADF00D);
        rready = 1;
        @(negedge clk);
        rready = 0;
        // Reset in the middle of a write aborts it completely.
        awaddr = 16'h0030; wdata = 32'hFFFF0000; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 20);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        we0 = we_total; bv0 = bv_total;
        #2 rst_n = 0;
        #1;
        check("arst_ctrl", 32'({awready, wready, arready, bvalid, rvalid, mem_we, bresp, rresp}), 0);
        check("arst_addr", 32'(mem_addr), 0);
        check("arst_wdata", mem_wdata, 0);
        repeat (2) @(negedge clk);
        araddr = 16'h0030; arvalid = 1;
        rst_n = 1;
        do_read(16'h0030, 1, 0);
        check("arst_no_we", we_total - we0, 0);
        check("arst_no_bv", bv_total - bv0, 0);
        bready = 0;
        for (int t = 0; t < 80; t++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h4000, 16'hFFFF))
                                            : 16'(($urandom_range(0, 31) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF,
                         1'($urandom_range(0, 1)), $urandom_range(0, 3));
            else
                do_read(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
